uart_rx: RTL and testbench
==========================

# uart_rx

UART serial receiver that sits directly downstream of the mod-M baud-rate tick generator. It consumes the generator's 16x-oversampling `max_tick` as its sampling strobe, detects and validates the start bit, and shifts in DBIT data bits LSB-first. It then checks the stop bit and presents the assembled word with a one-cycle done pulse to the receive FIFO or interface logic.

## Interface
- DBIT, 8: data bits per frame (5..9)
- SB_TICK, 16: ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- OVS, 16: oversampling ticks per bit; fixed at 16, and the tick counter is 4 bits wide
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- s_tick  input  1  one-clk strobe at 16x baud, driven from the baud generator `max_tick`
- rx  input  1  serial line, idle high, asynchronous to clk
- dout  output  DBIT  received word; valid while rx_done_tick=1, held until the next frame completes
- rx_done_tick  output  1  one-clk pulse when a frame completes
- frame_err  output  1  stop bit sampled low; valid with rx_done_tick
- parity_err  output  1  parity mismatch; valid with rx_done_tick

## Operation
- rx passes through a 2-flop synchronizer before use. Both flops reset to 1.
- State machine states: IDLE, START, DATA, PARITY (present only when the parity macro is defined), STOP.
- Internal registers:
  - s_cnt: 4-bit tick counter
  - n_cnt: bit counter, width clog2(DBIT)
  - b_reg: DBIT-bit shift register
- IDLE: when synchronized rx=0, go to START and set s_cnt=0. s_tick is not required for this transition.
- START: on each s_tick, increment s_cnt.
  - At s_cnt=7 (mid start bit), if rx=0, go to DATA with s_cnt=0 and n_cnt=0.
  - At s_cnt=7, if rx=1, treat it as a glitch: return to IDLE with no output.
- DATA: on each s_tick, increment s_cnt. At s_cnt=15:
  - set s_cnt=0 and b_reg={rx, b_reg[DBIT-1:1]} (LSB first);
  - if n_cnt=DBIT-1, go to PARITY (or STOP when parity is compiled out);
  - otherwise increment n_cnt.
- PARITY: at s_cnt=15, latch the parity bit and go to STOP with s_cnt=0.
- STOP: at s_cnt=SB_TICK-1 on an s_tick, assert rx_done_tick for exactly one clk and go to IDLE.
  - frame_err = ~rx, sampled on that same tick.
  - The s_cnt compare uses a counter wide enough for SB_TICK, i.e. 5 bits when SB_TICK>16.
- s_tick is ignored in IDLE. Outside IDLE, counters advance only on s_tick.
- frame_err and parity_err hold their values until the next rx_done_tick.
- Reset mid-frame returns immediately to IDLE. No done pulse is generated and partial data is discarded.

## Timing
- Reset values: state=IDLE, dout=0, rx_done_tick=0, frame_err=0, parity_err=0, all counters 0.
- The rx falling edge reaches FSM logic 2 clk after arrival (synchronizer delay).
- Every bit is sampled at tick 7 of its bit period: 8 ticks after the start edge, then every 16 ticks.
- rx_done_tick asserts one clk after the s_tick that ends STOP. dout is updated on that same edge.
- A new start bit seen in IDLE on the cycle right after the done pulse is accepted, so back-to-back frames lose no bits.

## Configuration
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is present; one even-parity bit follows the data.
  - parity_err = ^b_reg ^ parity_bit, registered with rx_done_tick.
- Undefined:
  - PARITY state is absent; the frame is start, data, stop.
  - The parity_err port still exists and is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the OVS=16 constant and the mid-bit sample index (7);
  - the default DBIT and SB_TICK values.
- One sub-module, sync_2ff: the rx synchronizer with a reset-to-1 parameter.
- The FSM and datapath stay flat in uart_rx.

## Test plan
- Stimulus for all scenarios: s_tick every 4 clk; bit period = 16 ticks.
- Frame 0xA5 with a valid stop bit -> dout=0xA5, one rx_done_tick, frame_err=0.
- rx low for 3 ticks then high -> no rx_done_tick; FSM back in IDLE.
- Frame 0x3C with the stop bit driven 0 -> dout=0x3C, frame_err=1.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two done pulses, dout=0x00 then 0xFF.
- reset asserted during bit 4 of a frame, then a clean frame 0x5A -> no pulse from the aborted frame; dout=0x5A afterwards.
- UART_RX_PARITY_EN defined, frame 0x07 sent with parity bit 0 -> parity_err=1. The same frame with parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and frame timing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_rx_state_e;

  localparam int unsigned Ovs           = 16;
  localparam int unsigned MidTick       = 7;
  localparam int unsigned DbitDefault   = 8;
  localparam int unsigned SbTickDefault = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to ResetVal.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling tick; samples each bit at mid-period.
// Even parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned Dbit   = DbitDefault,
  parameter int unsigned SbTick = SbTickDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick_i,
  input  logic            rx_i,
  output logic [Dbit-1:0] dout_o,
  output logic            rx_done_tick_o,
  output logic            frame_err_o,
  output logic            parity_err_o
);

  // Stop phase may last up to 32 ticks, so the tick counter widens to cover it.
  localparam int unsigned SCntW = (SbTick > Ovs) ? 5 : 4;
  localparam int unsigned NCntW = $clog2(Dbit);

  localparam logic [SCntW-1:0] SCntMid  = SCntW'(MidTick);
  localparam logic [SCntW-1:0] SCntLast = SCntW'(Ovs - 1);
  localparam logic [SCntW-1:0] SCntStop = SCntW'(SbTick - 1);
  localparam logic [NCntW-1:0] NCntLast = NCntW'(Dbit - 1);

  logic rx_sync;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rx_i),
    .q_o  (rx_sync)
  );

  uart_rx_state_e   state_q, state_d;
  logic [SCntW-1:0] s_cnt_q, s_cnt_d;
  logic [NCntW-1:0] n_cnt_q, n_cnt_d;
  logic [Dbit-1:0]  b_q, b_d;
  logic [Dbit-1:0]  dout_q, dout_d;
  logic             done_q, done_d;
  logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    b_d         = b_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = parity_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!rx_sync) begin
          state_d = StStart;
          s_cnt_d = '0;
        end
      end

      StStart: begin
        if (s_tick_i) begin
          if (s_cnt_q == SCntMid) begin
            if (!rx_sync) begin
              state_d = StData;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = StIdle;  // start-bit glitch
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      StData: begin
        if (s_tick_i) begin
          if (s_cnt_q == SCntLast) begin
            s_cnt_d = '0;
            b_d     = {rx_sync, b_q[Dbit-1:1]};
            if (n_cnt_q == NCntLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (s_tick_i) begin
          if (s_cnt_q == SCntLast) begin
            par_d   = rx_sync;
            s_cnt_d = '0;
            state_d = StStop;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`endif

      StStop: begin
        if (s_tick_i) begin
          if (s_cnt_q == SCntStop) begin
            done_d      = 1'b1;
            dout_d      = b_q;
            frame_err_d = ~rx_sync;
`ifdef UART_RX_PARITY_EN
            parity_err_d = (^b_q) ^ par_q;
`endif
            state_d     = StIdle;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout_o         = dout_q;
  assign rx_done_tick_o = done_q;
  assign frame_err_o    = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o   = parity_err_q;
`else
  assign parity_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: s_tick every 4 clk, 64 clk per bit, table of frames plus
// hand-written glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned BitClk = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  rec_t got[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    logic [7:0] exp_dout;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[$];

  uart_rx u_dut (
    .clk           (clk),
    .reset         (reset),
    .s_tick_i      (s_tick),
    .rx_i          (rx),
    .dout_o        (dout),
    .rx_done_tick_o(rx_done_tick),
    .frame_err_o   (frame_err),
    .parity_err_o  (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Record every done pulse; a stretched pulse shows up as an extra record.
  always @(negedge clk) begin
    if (rx_done_tick) got.push_back('{d: dout, fe: frame_err, pe: parity_err});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
    rx = 1'b0;
    repeat (BitClk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BitClk) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (BitClk) @(negedge clk);
`else
    if (par) rx = 1'b1;  // parity bit not part of the frame in this build
`endif
    rx = stop;
    repeat (BitClk) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0});
    vecs.push_back('{8'h6E, 1'b1, 1'b1, 8'h6E, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0});
`endif

    // Reset state, sampled while reset is held.
    repeat (5) @(negedge clk);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_done", 32'(rx_done_tick), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_perr", 32'(parity_err), 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_no_pulse", 32'(got.size()), 32'h0);

    foreach (vecs[k]) begin
      got.delete();
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].par);
      repeat (3 * BitClk) @(negedge clk);
      check($sformatf("vec%0d_pulses", k), 32'(got.size()), 32'h1);
      if (got.size() >= 1) begin
        check($sformatf("vec%0d_dout", k), 32'(got[0].d), 32'(vecs[k].exp_dout));
        check($sformatf("vec%0d_ferr", k), 32'(got[0].fe), 32'(vecs[k].exp_fe));
        check($sformatf("vec%0d_perr", k), 32'(got[0].pe), 32'(vecs[k].exp_pe));
      end
      check($sformatf("vec%0d_dout_held", k), 32'(dout), 32'(vecs[k].exp_dout));
      check($sformatf("vec%0d_ferr_held", k), 32'(frame_err), 32'(vecs[k].exp_fe));
    end

    // Start-bit glitch: 3 ticks low, then high.
    got.delete();
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BitClk) @(negedge clk);
    check("glitch_no_pulse", 32'(got.size()), 32'h0);
    check("glitch_idle", 32'(u_dut.state_q), 32'(StIdle));

    // Back-to-back frames with no idle gap.
    got.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (3 * BitClk) @(negedge clk);
    check("b2b_pulses", 32'(got.size()), 32'h2);
    if (got.size() == 2) begin
      check("b2b_first", 32'(got[0].d), 32'h00);
      check("b2b_second", 32'(got[1].d), 32'hFF);
    end

    // Reset in the middle of data bit 4, then a clean frame.
    got.delete();
    rx = 1'b0;
    repeat (BitClk) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BitClk) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BitClk / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_dout_cleared", 32'(dout), 32'h0);
    reset = 1'b0;
    repeat (10 * BitClk) @(negedge clk);
    check("abort_no_pulse", 32'(got.size()), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (3 * BitClk) @(negedge clk);
    check("after_abort_pulses", 32'(got.size()), 32'h1);
    check("after_abort_dout", 32'(dout), 32'h5A);
    check("after_abort_ferr", 32'(frame_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
